// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared beat type and constants for the stream_gen / stream_sink pair
//   DEFAULT_DEPTH : default FIFO depth for stream sinks
//   DATA_W        : stream byte width
//   beat_t        : {last, data} as stored per FIFO entry
package stream_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DATA_W        = 8;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/sink_fifo.sv
// rtl/sink_fifo.sv - synchronous beat_t FIFO with registered read data
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_i, wr_data_i   : write strobe (already qualified by ~full) and entry
//   rd_i, rd_data_o   : read strobe (already qualified by ~empty), registered head entry
//   full_o, empty_o   : occupancy flags
//   count_o           : current occupancy
module sink_fifo
  import stream_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  beat_t            wr_data_i,
  input  logic             rd_i,
  output beat_t            rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] diff;
  beat_t         rd_data_q, rd_data_d;
  beat_t         mem_q [DEPTH];

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rd_data_d = rd_data_q;
    if (wr_i) wptr_d = wptr_q + PW'(1);
    if (rd_i) begin
      rptr_d    = rptr_q + PW'(1);
      rd_data_d = mem_q[rptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

  assign diff      = wptr_q - rptr_q;
  assign count_o   = CNT_W'(diff);
  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/stream_sink.sv
// rtl/stream_sink.sv - AXI-Stream byte sink with FIFO, pop port and frame statistics
//   Optional macro STREAM_SINK_CHECK_EN adds an incrementing-pattern checker.
//   clk, rst                 : clock, asynchronous active-low reset
//   ip_en                    : accept enable (gates tready)
//   tdata/tvalid/tlast/tready: input stream
//   pop, Dout, dout_last, dout_valid : bench drain port, one-cycle pop latency
//   buff_count, empty, full  : FIFO occupancy
//   beat_count, frame_count, last_frame_len : frame statistics
//   overflow_drop            : sticky, stream offered while full
//   mismatch, err_count      : checker outputs (STREAM_SINK_CHECK_EN only)
module stream_sink
  import stream_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int CNT_W  = 4,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ip_en,
  input  logic [DATA_W-1:0] tdata,
  input  logic              tvalid,
  input  logic              tlast,
  output logic              tready,
  input  logic              pop,
  output logic [DATA_W-1:0] Dout,
  output logic              dout_last,
  output logic              dout_valid,
  output logic [CNT_W-1:0]  buff_count,
  output logic              empty,
  output logic              full,
  output logic [FCNT_W-1:0] beat_count,
  output logic [FCNT_W-1:0] frame_count,
  output logic [FCNT_W-1:0] last_frame_len,
`ifdef STREAM_SINK_CHECK_EN
  output logic              overflow_drop,
  output logic              mismatch,
  output logic [FCNT_W-1:0] err_count
`else
  output logic              overflow_drop
`endif
);

  logic  acc;
  logic  rd;
  beat_t wr_beat;
  beat_t rd_beat;

  logic              dout_valid_q, dout_valid_d;
  logic [FCNT_W-1:0] beat_q, beat_d;
  logic [FCNT_W-1:0] frame_q, frame_d;
  logic [FCNT_W-1:0] last_len_q, last_len_d;
  logic              ovf_q, ovf_d;

  // Full only depends on registered pointers, so tready never loops back through tvalid.
  assign tready = ip_en & ~full;
  assign acc    = tvalid & tready;
  assign rd     = pop & ~empty;

  assign wr_beat.last = tlast;
  assign wr_beat.data = tdata;

  sink_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .wr_i      (acc),
    .wr_data_i (wr_beat),
    .rd_i      (rd),
    .rd_data_o (rd_beat),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (buff_count)
  );

  // beat_count == 0 is the idle state; a tlast beat always returns it there.
  always_comb begin
    dout_valid_d = rd;
    beat_d       = beat_q;
    frame_d      = frame_q;
    last_len_d   = last_len_q;
    ovf_d        = ovf_q | (tvalid & ip_en & full);
    if (acc) begin
      if (tlast) begin
        last_len_d = beat_q + FCNT_W'(1);
        beat_d     = '0;
        frame_d    = frame_q + FCNT_W'(1);
      end else begin
        beat_d = beat_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_valid_q <= 1'b0;
      beat_q       <= '0;
      frame_q      <= '0;
      last_len_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      dout_valid_q <= dout_valid_d;
      beat_q       <= beat_d;
      frame_q      <= frame_d;
      last_len_q   <= last_len_d;
      ovf_q        <= ovf_d;
    end
  end

  assign Dout           = rd_beat.data;
  assign dout_last      = rd_beat.last;
  assign dout_valid     = dout_valid_q;
  assign beat_count     = beat_q;
  assign frame_count    = frame_q;
  assign last_frame_len = last_len_q;
  assign overflow_drop  = ovf_q;

`ifdef STREAM_SINK_CHECK_EN
  // Expected pattern is 0,1,2,... within each frame, restarting after tlast.
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [FCNT_W-1:0] err_q, err_d;
  logic              mism_q, mism_d;

  always_comb begin
    exp_d  = exp_q;
    err_d  = err_q;
    mism_d = mism_q;
    if (acc) begin
      exp_d = tlast ? '0 : exp_q + DATA_W'(1);
      if (tdata != exp_q) begin
        err_d  = err_q + FCNT_W'(1);
        mism_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q  <= '0;
      err_q  <= '0;
      mism_q <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      err_q  <= err_d;
      mism_q <= mism_d;
    end
  end

  assign mismatch  = mism_q;
  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_stream_sink.sv
// tb/tb_stream_sink.sv - directed self-checking bench for stream_sink
module tb_stream_sink;

  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int FCNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ip_en;
  logic [7:0]        tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;
  logic              pop;
  logic [7:0]        Dout;
  logic              dout_last;
  logic              dout_valid;
  logic [CNT_W-1:0]  buff_count;
  logic              empty;
  logic              full;
  logic [FCNT_W-1:0] beat_count;
  logic [FCNT_W-1:0] frame_count;
  logic [FCNT_W-1:0] last_frame_len;
  logic              overflow_drop;
`ifdef STREAM_SINK_CHECK_EN
  logic              mismatch;
  logic [FCNT_W-1:0] err_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  stream_sink #(
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .FCNT_W (FCNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ip_en          (ip_en),
    .tdata          (tdata),
    .tvalid         (tvalid),
    .tlast          (tlast),
    .tready         (tready),
    .pop            (pop),
    .Dout           (Dout),
    .dout_last      (dout_last),
    .dout_valid     (dout_valid),
    .buff_count     (buff_count),
    .empty          (empty),
    .full           (full),
    .beat_count     (beat_count),
    .frame_count    (frame_count),
    .last_frame_len (last_frame_len),
`ifdef STREAM_SINK_CHECK_EN
    .overflow_drop  (overflow_drop),
    .mismatch       (mismatch),
    .err_count      (err_count)
`else
    .overflow_drop  (overflow_drop)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic pop_one(input string tag, input logic [7:0] d, input logic l);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check({tag, "_valid"}, dout_valid, 1);
    check({tag, "_data"}, Dout, d);
    check({tag, "_last"}, dout_last, l);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tready"}, tready, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_cnt"}, buff_count, 0);
    check({tag, "_dout"}, Dout, 0);
    check({tag, "_dlast"}, dout_last, 0);
    check({tag, "_dvalid"}, dout_valid, 0);
    check({tag, "_beat"}, beat_count, 0);
    check({tag, "_frame"}, frame_count, 0);
    check({tag, "_flen"}, last_frame_len, 0);
    check({tag, "_ovf"}, overflow_drop, 0);
  endtask

  initial begin
    rst = 1'b0; ip_en = 1'b0; tdata = 8'h00; tvalid = 1'b0; tlast = 1'b0; pop = 1'b0;
    tick(); tick();
    check_reset_state("rst");
    rst = 1'b1;
    ip_en = 1'b1;
    tick();
    check("idle_tready", tready, 1);
    check("idle_empty", empty, 1);
    check("idle_cnt", buff_count, 0);
    check("idle_frame", frame_count, 0);

    // Three-beat frame, then drain it.
    push(8'h00, 1'b0);
    push(8'h01, 1'b0);
    push(8'h02, 1'b1);
    check("f1_cnt", buff_count, 3);
    check("f1_frame", frame_count, 1);
    check("f1_flen", last_frame_len, 3);
    check("f1_beat", beat_count, 0);
    pop_one("f1_p0", 8'h00, 1'b0);
    pop_one("f1_p1", 8'h01, 1'b0);
    pop_one("f1_p2", 8'h02, 1'b1);
    tick();
    check("f1_dvalid_drop", dout_valid, 0);
    check("f1_empty", empty, 1);

    // Fill to full and hold tvalid.
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b0);
    check("full_flag", full, 1);
    check("full_tready", tready, 0);
    check("full_cnt", buff_count, 8);
    tdata = 8'h18; tvalid = 1'b1;
    tick();
    check("full_ovf", overflow_drop, 1);
    check("full_hold_cnt", buff_count, 8);
    pop = 1'b1;
    #1;
    check("full_pop_no_bypass", tready, 0);
    tick();
    pop = 1'b0;
    check("full_pop_valid", dout_valid, 1);
    check("full_pop_data", Dout, 8'h10);
    check("full_pop_cnt", buff_count, 7);
    check("full_pop_tready", tready, 1);
    tick();
    tvalid = 1'b0;
    check("full_refill_cnt", buff_count, 8);
    check("full_beat", beat_count, 9);
    pop = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("drain_data", Dout, 8'h10 + 8'(i));
      check("drain_valid", dout_valid, 1);
    end
    pop = 1'b0;
    check("drain_empty", empty, 1);
    push(8'h19, 1'b1);
    check("f2_frame", frame_count, 2);
    check("f2_flen", last_frame_len, 10);
    pop_one("f2_p", 8'h19, 1'b1);

    // Pop while empty is ignored.
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("empty_pop_valid", dout_valid, 0);
    check("empty_pop_hold", Dout, 8'h19);

    // Simultaneous accept and pop at occupancy 4, long enough to wrap pointers.
    for (int i = 0; i < 4; i++) begin
      push(8'h20 + 8'(i), 1'b0);
      q.push_back(8'h20 + 8'(i));
    end
    check("wrap_start_cnt", buff_count, 4);
    for (int i = 0; i < 20; i++) begin
      tdata  = 8'h30 + 8'(i);
      tlast  = (i == 19);
      tvalid = 1'b1;
      pop    = 1'b1;
      q.push_back(8'h30 + 8'(i));
      tick();
      check("wrap_cnt", buff_count, 4);
      check("wrap_data", Dout, q.pop_front());
    end
    tvalid = 1'b0; tlast = 1'b0; pop = 1'b0;
    check("wrap_frame", frame_count, 3);
    check("wrap_flen", last_frame_len, 24);
    check("wrap_beat", beat_count, 0);
    for (int i = 0; i < 4; i++) pop_one("wrap_tail", q.pop_front(), i == 3);

    // ip_en dropped mid-frame keeps beat_count.
    push(8'h40, 1'b0);
    push(8'h41, 1'b0);
    ip_en = 1'b0;
    #1;
    check("ipen_tready", tready, 0);
    tdata = 8'h42; tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    check("ipen_beat", beat_count, 2);
    check("ipen_cnt", buff_count, 2);
    ip_en = 1'b1;
    pop_one("mid_p", 8'h40, 1'b0);

    // Asynchronous reset mid-frame, away from any clock edge.
    #2;
    rst = 1'b0;
    ip_en = 1'b0;
    #1;
    check_reset_state("async");
    tick();
    rst = 1'b1;
    ip_en = 1'b1;

`ifdef STREAM_SINK_CHECK_EN
    check("chk_init", mismatch, 0);
    push(8'h00, 1'b0);
    push(8'h01, 1'b0);
    push(8'h05, 1'b1);
    check("chk_err", err_count, 1);
    check("chk_mism", mismatch, 1);
    push(8'h00, 1'b1);
    check("chk_reseed", err_count, 1);
    check("chk_sticky", mismatch, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
